fetch_stage: RTL

- Instruction-fetch stage of the 3-stage RV32I core.
- Owns the fetch PC and drives the synchronous-read BIOS and IMEM ports.
- Selects the returned word and delivers {instruction, pc, valid} to decode, where it feeds immediate generation and control.
- Handles stall, redirect (branch/jump from execute), boot bubble, and fetch faults.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 3-stage RV32I core.
// Optional FETCH_INSTRET_EN adds the fetch_count retired-fetch counter.
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h4000_0000,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013,
   parameter logic [3:0]  BIOS_NIBBLE = 4'h4,
   parameter logic [3:0]  IMEM_NIBBLE = 4'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_addr,
   output logic        fetch_en,
   input  logic [31:0] bios_rdata,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        inst_valid,
`ifdef FETCH_INSTRET_EN
   output logic [31:0] fetch_count,
`endif
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] next_pc;
   logic        in_bios;
   logic        in_imem;
   logic        pc_bad;

   assign in_bios = (fetch_pc[31:28] == BIOS_NIBBLE);
   assign in_imem = (fetch_pc[31:28] == IMEM_NIBBLE);
   assign pc_bad  = (fetch_pc[1:0] != 2'b00) || !(in_bios || in_imem);

   // State and fetch PC register; fetch_pc tracks the address whose data
   // is arriving from the memories this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= next_pc;
      end
   end

   // Next-PC selection, next-state logic and the decode-facing outputs.
   always_comb begin
      next_pc     = fetch_pc + 32'd4;
      state_nxt   = state;
      inst_out    = NOP_INST;
      inst_valid  = 1'b0;
      fetch_fault = 1'b0;

      if (rst) begin
         next_pc = RESET_PC;
      end else if (redirect_valid) begin
         next_pc = redirect_pc;
      end else if (state == BOOT || state == FAULT || stall) begin
         next_pc = fetch_pc;
      end

      if (!rst) begin
         unique case (state)
            BOOT: begin
               state_nxt = RUN;
            end
            RUN: begin
               if (redirect_valid) begin
                  state_nxt = RUN;
               end else if (pc_bad) begin
                  state_nxt   = FAULT;
                  fetch_fault = 1'b1;
               end else begin
                  inst_valid = 1'b1;
                  inst_out   = in_bios ? bios_rdata : imem_rdata;
               end
            end
            FAULT: begin
               fetch_fault = 1'b1;
               if (redirect_valid) state_nxt = RUN;
            end
            default: begin
               state_nxt = BOOT;
            end
         endcase
      end
   end

   assign fetch_addr = next_pc;
   assign fetch_en   = !rst;
   assign pc_out     = fetch_pc;

`ifdef FETCH_INSTRET_EN
   // Count instructions actually handed to decode (valid and accepted).
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 32'd0;
      end else if (inst_valid && !stall) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule
